// File: rtl/gj_pkg.sv
// Shared types and saturating fixed-point helpers for the Gauss-Jordan inverter and its divider.
package gj_pkg;

  localparam int FRAC_DEF = 8;
  localparam int ONE_FX   = 1 << FRAC_DEF;

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT,
    S_SEARCH,
    S_SWAP,
    S_RECIP,
    S_NORM,
    S_ELIM,
    S_OUT,
    S_DONE
  } t_gj_state;

  // Clamp a wide signed value into the two's-complement range of a w-bit word.
  function automatic logic signed [63:0] sat_w(input logic signed [63:0] x, input int w);
    logic signed [63:0] mx;
    logic signed [63:0] mn;
    mx = (64'sd1 <<< (w - 1)) - 64'sd1;
    mn = -(64'sd1 <<< (w - 1));
    if (x > mx) return mx;
    if (x < mn) return mn;
    return x;
  endfunction

  function automatic logic signed [63:0] mul_fx(input logic signed [63:0] a,
                                                input logic signed [63:0] b,
                                                input int frac, input int w);
    logic signed [63:0] prod;
    prod = a * b;
    return sat_w(prod >>> frac, w);
  endfunction

endpackage

// File: rtl/gj_inverse_seq_if.sv
// Load / control / result-stream bundle between the matrix source, the inverter and the consumer.
interface gj_inverse_seq_if #(
  parameter int N = 5,
  parameter int W = 16
);
  localparam int AW = $clog2(N * N);

  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic [W-1:0]  ld_data;
  logic          start;
  logic          busy;
  logic          done;
  logic          singular;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic [W-1:0]  out_data;

  modport master (
    output ld_valid, ld_addr, ld_data, start, out_ready,
    input  busy, done, singular, out_valid, out_addr, out_data
  );

  modport slave (
    input  ld_valid, ld_addr, ld_data, start, out_ready,
    output busy, done, singular, out_valid, out_addr, out_data
  );
endinterface

// File: rtl/fx_div_seq.sv
// Restoring signed divider, one quotient bit per cycle; quotient truncates toward zero and saturates to W bits.
module fx_div_seq
  import gj_pkg::*;
#(
  parameter int W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic signed [2*W-1:0] num,
  input  logic signed [W-1:0]   den,
  output logic                  done,
  output logic signed [W-1:0]   quo
);
  localparam int CNW = $clog2(2 * W + 1);

  logic [2*W-1:0] q;
  logic [W-1:0]   rem;
  logic [W-1:0]   dmag;
  logic           neg;
  logic [CNW-1:0] cnt;
  logic [W:0]     shifted;
  logic [W:0]     diff;
  logic signed [63:0] qs;

  always_comb begin
    shifted = {rem, q[2*W-1]};
    diff    = shifted - {1'b0, dmag};
    qs      = $signed(64'(q));
    quo     = W'(sat_w(neg ? -qs : qs, W));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q    <= '0;
      rem  <= '0;
      dmag <= '0;
      neg  <= 1'b0;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        q    <= num[2*W-1] ? (2*W)'(-num) : (2*W)'(num);
        dmag <= den[W-1] ? W'(-den) : W'(den);
        neg  <= num[2*W-1] ^ den[W-1];
        rem  <= '0;
        cnt  <= CNW'(2 * W);
      end else if (cnt != '0) begin
        q   <= {q[2*W-2:0], ~diff[W]};
        rem <= diff[W] ? shifted[W-1:0] : diff[W-1:0];
        cnt <= cnt - 1'b1;
        if (cnt == CNW'(1)) done <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/gj_inverse_seq.sv
// Sequential Gauss-Jordan matrix inverter with partial pivoting; streams inv(A) row-major over valid/ready.
module gj_inverse_seq
  import gj_pkg::*;
#(
  parameter int N    = 5,
  parameter int W    = 16,
  parameter int FRAC = 8
) (
  input  logic              clk,
  input  logic              reset,
  gj_inverse_seq_if.slave   bus
);
  localparam int AW = $clog2(N * N);
  localparam int RW = $clog2(N + 1);
  localparam int CW = $clog2(2 * N + 1);
  localparam logic signed [W-1:0] ONE     = W'(1 << FRAC);
  localparam logic [2*W-1:0]      RCP_NUM = (2*W)'(64'd1 << (2 * FRAC));
  localparam logic [RW-1:0]       RLAST   = RW'(N - 1);
  localparam logic [CW-1:0]       CLAST   = CW'(N - 1);
  localparam logic [CW-1:0]       C2LAST  = CW'(2 * N - 1);
  localparam logic [AW-1:0]       OLAST   = AW'(N * N - 1);

  t_gj_state state;
  logic signed [W-1:0] a_m [N*N];
  logic signed [W-1:0] b_m [N*N];
  logic [RW-1:0] r, k, p, next_r, best_p;
  logic [CW-1:0] c, cc;
  logic [AW-1:0] oaddr;
  logic signed [W-1:0] rcp, f_reg, f_use, piv, xk, xr, prod, diff, cur, best_val;
  logic signed [W-1:0] div_den, div_quo;
  logic [W-1:0] pmax, cur_abs, best_abs;
  logic col_b, take, row_end, div_start, div_done, singular_q;

  function automatic int ix(input int rr, input int cl);
    return rr * N + cl;
  endfunction

  // Columns 0..N-1 address A, N..2N-1 address B, so NORM/ELIM sweep the augmented row in one pass.
  always_comb begin
    col_b    = (c > CLAST);
    cc       = col_b ? c - CW'(N) : c;
    xk       = col_b ? b_m[ix(int'(k), int'(cc))] : a_m[ix(int'(k), int'(cc))];
    xr       = col_b ? b_m[ix(int'(r), int'(cc))] : a_m[ix(int'(r), int'(cc))];
    cur      = a_m[ix(int'(r), int'(k))];
    f_use    = (c == '0) ? cur : f_reg;
    prod     = W'(mul_fx(64'(xk), (state == S_NORM) ? 64'(rcp) : 64'(f_use), FRAC, W));
    diff     = W'(sat_w(64'(xr) - 64'(prod), W));
    cur_abs  = cur[W-1] ? W'(-cur) : W'(cur);
    take     = (r == k) || (cur_abs > pmax);
    best_abs = take ? cur_abs : pmax;
    best_p   = take ? r : p;
    best_val = take ? cur : piv;
    next_r   = (r + 1'b1 == k) ? r + RW'(2) : r + 1'b1;
    row_end  = (f_use == '0) || (c == C2LAST);
    div_start = ((state == S_SEARCH) && (r == RLAST) && (best_abs != '0) && (best_p == k)) ||
                ((state == S_SWAP) && (c == CLAST));
    div_den   = (state == S_SEARCH) ? best_val : piv;
  end

  fx_div_seq #(.W(W)) u_div (
    .clk   (clk),
    .reset (reset),
    .start (div_start),
    .num   (RCP_NUM),
    .den   (div_den),
    .done  (div_done),
    .quo   (div_quo)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      singular_q <= 1'b0;
      r <= '0; c <= '0; k <= '0; p <= '0;
      oaddr <= '0; rcp <= '0; f_reg <= '0; piv <= '0; pmax <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.ld_valid && (int'(bus.ld_addr) < N * N)) a_m[int'(bus.ld_addr)] <= bus.ld_data;
          if (bus.start) begin
            state      <= S_INIT;
            singular_q <= 1'b0;
            r <= '0;
            c <= '0;
          end
        end
        S_INIT: begin
          b_m[ix(int'(r), int'(c))] <= (int'(r) == int'(c)) ? ONE : '0;
          if (c == CLAST) begin
            c <= '0;
            r <= r + 1'b1;
            if (r == RLAST) begin
              state <= S_SEARCH;
              k <= '0;
              r <= '0;
            end
          end else c <= c + 1'b1;
        end
        S_SEARCH: begin
          if (take) begin
            pmax <= cur_abs;
            p    <= r;
            piv  <= cur;
          end
          if (r == RLAST) begin
            c <= '0;
            if (best_abs == '0) begin
              singular_q <= 1'b1;
              state      <= S_DONE;
            end else if (best_p != k) state <= S_SWAP;
            else state <= S_RECIP;
          end else r <= r + 1'b1;
        end
        S_SWAP: begin
          a_m[ix(int'(k), int'(c))] <= a_m[ix(int'(p), int'(c))];
          a_m[ix(int'(p), int'(c))] <= a_m[ix(int'(k), int'(c))];
          b_m[ix(int'(k), int'(c))] <= b_m[ix(int'(p), int'(c))];
          b_m[ix(int'(p), int'(c))] <= b_m[ix(int'(k), int'(c))];
          if (c == CLAST) state <= S_RECIP;
          else c <= c + 1'b1;
        end
        S_RECIP: begin
          if (div_done) begin
            rcp   <= div_quo;
            c     <= '0;
            state <= S_NORM;
          end
        end
        S_NORM: begin
          if (col_b) b_m[ix(int'(k), int'(cc))] <= prod;
          else       a_m[ix(int'(k), int'(cc))] <= prod;
          if (c == C2LAST) begin
            c     <= '0;
            r     <= (k == '0) ? RW'(1) : '0;
            state <= S_ELIM;
          end else c <= c + 1'b1;
        end
        S_ELIM: begin
          // The multiplier factor must be latched before column k of this row is overwritten.
          if (c == '0) f_reg <= f_use;
          if (f_use != '0) begin
            if (col_b) b_m[ix(int'(r), int'(cc))] <= diff;
            else       a_m[ix(int'(r), int'(cc))] <= diff;
          end
          if (row_end) begin
            c <= '0;
            if (next_r > RLAST) begin
              if (k == RLAST) begin
                state <= S_OUT;
                oaddr <= '0;
              end else begin
                k     <= k + 1'b1;
                r     <= k + 1'b1;
                state <= S_SEARCH;
              end
            end else r <= next_r;
          end else c <= c + 1'b1;
        end
        S_OUT: begin
          if (bus.out_ready) begin
            if (oaddr == OLAST) state <= S_DONE;
            else oaddr <= oaddr + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = (state != S_IDLE) && (state != S_DONE);
  assign bus.done      = (state == S_DONE);
  assign bus.singular  = singular_q;
  assign bus.out_valid = (state == S_OUT);
  assign bus.out_addr  = (state == S_OUT) ? oaddr : '0;
  assign bus.out_data  = (state == S_OUT) ? b_m[int'(oaddr)] : '0;

endmodule
